spi_clkgen: RTL

SPI serial-clock and slave-select sequencer sitting directly upstream of the SPI shift core. It divides the system clock into SCK, emits single-cycle `pos_edge_o`/`neg_edge_o` strobes that the core uses to shift and count, and frames each transfer with NSS setup and hold delays. It stops SCK once the core reports its last bit via `last_i`.

---
 rtl/spi_clkgen.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/spi_clkgen.sv
// SPI SCK / slave-select sequencer: divides clk_i into SCK, issues edge strobes
// for the shift core and frames each transfer with NSS setup and hold delays.
module spi_clkgen #(
  parameter int DIV_WIDTH = 8,
  parameter int CS_NUM    = 4,
  parameter int DLY_WIDTH = 4,
  localparam int CSV_WIDTH = (CS_NUM > 1) ? $clog2(CS_NUM) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic                 st_i,
  input  logic [DIV_WIDTH-1:0] div_i,
  input  logic                 cpol_i,
  input  logic [CSV_WIDTH-1:0] csv_i,
  input  logic [DLY_WIDTH-1:0] dly_i,
  input  logic                 last_i,
  output logic                 spi_clk_o,
  output logic                 pos_edge_o,
  output logic                 neg_edge_o,
  output logic [CS_NUM-1:0]    spi_nss_o,
  output logic                 busy_o,
  output logic                 done_o
);

  typedef enum logic [1:0] {IDLE, SETUP, RUN, HOLD} state_t;

  state_t                 state_reg, state_next;
  logic [DIV_WIDTH-1:0]   div_reg, div_next;
  logic                   cpol_reg, cpol_next;
  logic [DLY_WIDTH-1:0]   dly_reg, dly_next;
  logic [DIV_WIDTH-1:0]   cnt_reg, cnt_next;
  logic [DLY_WIDTH-1:0]   dly_cnt_reg, dly_cnt_next;
  logic                   sck_reg, sck_next;
  logic [CS_NUM-1:0]      nss_reg, nss_next;
  logic                   done_reg, done_next;
  logic                   lead_seen_reg, lead_seen_next;
  logic                   pos_edge, neg_edge;
  logic                   go_hold;
  logic                   tick;
  logic [CS_NUM-1:0]      sel_mask;

  // One-hot decode of the requested slave, applied only when a start is accepted.
  generate
    for (genvar gi = 0; gi < CS_NUM; gi++) begin : g_sel
      assign sel_mask[gi] = (int'(csv_i) == gi);
    end
  endgenerate

  assign tick = (cnt_reg == '0);

  always_comb begin
    state_next     = state_reg;
    div_next       = div_reg;
    cpol_next      = cpol_reg;
    dly_next       = dly_reg;
    cnt_next       = cnt_reg;
    dly_cnt_next   = dly_cnt_reg;
    sck_next       = sck_reg;
    nss_next       = nss_reg;
    done_next      = 1'b0;
    lead_seen_next = lead_seen_reg;
    pos_edge       = 1'b0;
    neg_edge       = 1'b0;
    go_hold        = 1'b0;

    if (!en_i) begin
      state_next     = IDLE;
      nss_next       = '1;
      sck_next       = cpol_i;
      cnt_next       = '0;
      dly_cnt_next   = '0;
      lead_seen_next = 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          sck_next = cpol_i;
          if (st_i) begin
            div_next       = div_i;
            cpol_next      = cpol_i;
            dly_next       = dly_i;
            cnt_next       = div_i;
            dly_cnt_next   = dly_i;
            lead_seen_next = 1'b0;
            nss_next       = ~sel_mask;
            state_next     = (dly_i == '0) ? RUN : SETUP;
          end
        end

        SETUP: begin
          if (tick) begin
            cnt_next = div_reg;
            if (dly_cnt_reg == DLY_WIDTH'(1)) begin
              state_next = RUN;
            end else begin
              dly_cnt_next = dly_cnt_reg - DLY_WIDTH'(1);
            end
          end else begin
            cnt_next = cnt_reg - DIV_WIDTH'(1);
          end
        end

        RUN: begin
          if (tick) begin
            cnt_next = div_reg;
            if (sck_reg != cpol_reg) begin
              // Trailing edge always completes; last_i may then end the run.
              sck_next = cpol_reg;
              pos_edge = ~sck_reg;
              neg_edge = sck_reg;
              go_hold  = last_i;
            end else if (last_i && lead_seen_reg) begin
              go_hold = 1'b1;
            end else begin
              sck_next       = ~sck_reg;
              pos_edge       = ~sck_reg;
              neg_edge       = sck_reg;
              lead_seen_next = 1'b1;
            end

            if (go_hold) begin
              if (dly_reg == '0) begin
                state_next = IDLE;
                nss_next   = '1;
                done_next  = 1'b1;
              end else begin
                state_next   = HOLD;
                dly_cnt_next = dly_reg;
              end
            end
          end else begin
            cnt_next = cnt_reg - DIV_WIDTH'(1);
          end
        end

        HOLD: begin
          if (tick) begin
            cnt_next = div_reg;
            if (dly_cnt_reg == DLY_WIDTH'(1)) begin
              state_next = IDLE;
              nss_next   = '1;
              done_next  = 1'b1;
            end else begin
              dly_cnt_next = dly_cnt_reg - DLY_WIDTH'(1);
            end
          end else begin
            cnt_next = cnt_reg - DIV_WIDTH'(1);
          end
        end

        default: begin
          state_next = IDLE;
          nss_next   = '1;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg     <= IDLE;
      div_reg       <= '0;
      cpol_reg      <= 1'b0;
      dly_reg       <= '0;
      cnt_reg       <= '0;
      dly_cnt_reg   <= '0;
      sck_reg       <= 1'b0;
      nss_reg       <= '1;
      done_reg      <= 1'b0;
      lead_seen_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      div_reg       <= div_next;
      cpol_reg      <= cpol_next;
      dly_reg       <= dly_next;
      cnt_reg       <= cnt_next;
      dly_cnt_reg   <= dly_cnt_next;
      sck_reg       <= sck_next;
      nss_reg       <= nss_next;
      done_reg      <= done_next;
      lead_seen_reg <= lead_seen_next;
    end
  end

  // Strobes mark the cycle whose closing edge moves SCK, so they lead it by one.
  assign spi_clk_o  = sck_reg;
  assign pos_edge_o = pos_edge;
  assign neg_edge_o = neg_edge;
  assign spi_nss_o  = nss_reg;
  assign busy_o     = (state_reg != IDLE);
  assign done_o     = done_reg;

endmodule
